// File: rtl/mem_responder.sv
// mem_responder: answers IF-stage instruction fetches and MEM-stage data
// reads/writes from one single-ported word array, using a fixed access latency
// and a request/ack handshake. The data channel wins over fetch in IDLE.
// Optional macro MEM_RESPONDER_STATS_EN adds saturating per-kind completion
// counters (stat_ifetch, stat_dread, stat_dwrite).
module mem_responder #(
  parameter int WORD_SIZE = 16,
  parameter int ADDR_BITS = 8,
  parameter int LATENCY   = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_readM,
  input  logic [WORD_SIZE-1:0] i_address,
  output logic [WORD_SIZE-1:0] i_data,
  output logic                 i_ack,
  input  logic                 d_readM,
  input  logic                 d_writeM,
  input  logic [WORD_SIZE-1:0] d_address,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic [WORD_SIZE-1:0] d_rdata,
  output logic                 d_ack,
  output logic                 busy
`ifdef MEM_RESPONDER_STATS_EN
  ,
  output logic [WORD_SIZE-1:0] stat_ifetch,
  output logic [WORD_SIZE-1:0] stat_dread,
  output logic [WORD_SIZE-1:0] stat_dwrite
`endif
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;

  // Word array; deliberately not reset so it can map onto block RAM.
  logic [WORD_SIZE-1:0] mem [0:DEPTH-1];

  logic [1:0]           state_q, state_d;
  logic [3:0]           counter_q, counter_d;
  logic                 chan_q, chan_d;      // 1 = data channel, 0 = fetch
  logic                 write_q, write_d;
  logic [ADDR_BITS-1:0] index_q, index_d;
  logic [WORD_SIZE-1:0] wdata_q, wdata_d;
  logic [WORD_SIZE-1:0] i_data_q, i_data_d;
  logic [WORD_SIZE-1:0] d_rdata_q, d_rdata_d;
  logic                 i_ack_q, i_ack_d;
  logic                 d_ack_q, d_ack_d;

  logic ack_fire;
  logic mem_we;

  // Upper address bits wrap away; kept here only to show they are ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_address[WORD_SIZE-1:ADDR_BITS],
                              d_address[WORD_SIZE-1:ADDR_BITS]};

  // The access happens on the edge that leaves BUSY with the counter spent.
  assign ack_fire = (state_q == S_BUSY) && (counter_q == 4'd0);
  assign mem_we   = ack_fire && chan_q && write_q;

  // Next-state logic: sample requests only in IDLE, count down, then pulse ack.
  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    chan_d    = chan_q;
    write_d   = write_q;
    index_d   = index_q;
    wdata_d   = wdata_q;
    i_data_d  = i_data_q;
    d_rdata_d = d_rdata_q;
    i_ack_d   = i_ack_q;
    d_ack_d   = d_ack_q;
    case (state_q)
      S_IDLE: begin
        if (d_readM || d_writeM) begin
          // A simultaneous read+write is handled as a write.
          chan_d    = 1'b1;
          write_d   = d_writeM;
          index_d   = d_address[ADDR_BITS-1:0];
          wdata_d   = d_wdata;
          counter_d = 4'(LATENCY - 1);
          state_d   = S_BUSY;
        end else if (i_readM) begin
          chan_d    = 1'b0;
          write_d   = 1'b0;
          index_d   = i_address[ADDR_BITS-1:0];
          counter_d = 4'(LATENCY - 1);
          state_d   = S_BUSY;
        end
      end
      S_BUSY: begin
        if (counter_q != 4'd0) begin
          counter_d = counter_q - 4'd1;
        end else begin
          state_d = S_ACK;
          if (chan_q) begin
            d_ack_d = 1'b1;
            if (!write_q) begin
              d_rdata_d = mem[index_q];
            end
          end else begin
            i_ack_d  = 1'b1;
            i_data_d = mem[index_q];
          end
        end
      end
      S_ACK: begin
        // No sampling here, so a request still held high is not taken twice.
        i_ack_d = 1'b0;
        d_ack_d = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control and output registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      counter_q <= 4'd0;
      chan_q    <= 1'b0;
      write_q   <= 1'b0;
      index_q   <= '0;
      wdata_q   <= '0;
      i_data_q  <= '0;
      d_rdata_q <= '0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      chan_q    <= chan_d;
      write_q   <= write_d;
      index_q   <= index_d;
      wdata_q   <= wdata_d;
      i_data_q  <= i_data_d;
      d_rdata_q <= d_rdata_d;
      i_ack_q   <= i_ack_d;
      d_ack_q   <= d_ack_d;
    end
  end

  // Array write port; commits only on the ack edge of a data write.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[index_q] <= wdata_q;
    end
  end

  assign i_data  = i_data_q;
  assign d_rdata = d_rdata_q;
  assign i_ack   = i_ack_q;
  assign d_ack   = d_ack_q;
  assign busy    = (state_q != S_IDLE);

`ifdef MEM_RESPONDER_STATS_EN
  // Bit 0 = fetch, bit 1 = data read, bit 2 = data write.
  logic [2:0] stat_inc;
  assign stat_inc = {ack_fire &  chan_q &  write_q,
                     ack_fire &  chan_q & ~write_q,
                     ack_fire & ~chan_q};

  for (genvar gi = 0; gi < 3; gi++) begin : g_stat
    logic [WORD_SIZE-1:0] cnt_q, cnt_d;

    // Saturating increment on this kind's ack edge.
    always_comb begin
      cnt_d = cnt_q;
      if (stat_inc[gi] && (cnt_q != {WORD_SIZE{1'b1}})) begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    // Counter register.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end
  end

  assign stat_ifetch = g_stat[0].cnt_q;
  assign stat_dread  = g_stat[1].cnt_q;
  assign stat_dwrite = g_stat[2].cnt_q;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Testbench for mem_responder: directed steps followed by random transactions,
// checked against an array model of memory plus the handshake timing rules.
module tb_mem_responder;
  localparam int WS  = 16;
  localparam int AB  = 8;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          i_readM = 1'b0;
  logic [WS-1:0] i_address = '0;
  logic [WS-1:0] i_data;
  logic          i_ack;
  logic          d_readM = 1'b0;
  logic          d_writeM = 1'b0;
  logic [WS-1:0] d_address = '0;
  logic [WS-1:0] d_wdata = '0;
  logic [WS-1:0] d_rdata;
  logic          d_ack;
  logic          busy;
`ifdef MEM_RESPONDER_STATS_EN
  logic [WS-1:0] stat_ifetch, stat_dread, stat_dwrite;
`endif

  mem_responder #(.WORD_SIZE(WS), .ADDR_BITS(AB), .LATENCY(LAT)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_readM(i_readM), .i_address(i_address), .i_data(i_data), .i_ack(i_ack),
    .d_readM(d_readM), .d_writeM(d_writeM), .d_address(d_address),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ack(d_ack), .busy(busy)
`ifdef MEM_RESPONDER_STATS_EN
    , .stat_ifetch(stat_ifetch), .stat_dread(stat_dread), .stat_dwrite(stat_dwrite)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [WS-1:0] model_mem [256];
  logic [WS-1:0] exp_i_data = '0;
  logic [WS-1:0] exp_d_rdata = '0;
  int n_if = 0, n_dr = 0, n_dw = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for the chosen ack; returns negedges elapsed.
  task automatic wait_ack(input bit want_d, output int cycles, output bit ok);
    cycles = 0;
    ok = 1'b0;
    while (cycles < 40 && !ok) begin
      @(negedge clk);
      cycles++;
      check("ack_overlap", {31'd0, i_ack & d_ack}, 32'd0);
      if (want_d ? d_ack : i_ack) ok = 1'b1;
    end
  endtask

  // kind: 0 fetch, 1 data read, 2 data write, 3 read+write (acts as write).
  // Called at a negedge with the DUT idle; returns at a negedge, idle again.
  task automatic do_txn(input int kind, input logic [WS-1:0] addr,
                        input logic [WS-1:0] wd, input bit scramble);
    int cyc;
    bit ok;
    logic [7:0] idx;
    idx = addr[7:0];
    case (kind)
      0: begin i_readM = 1'b1; i_address = addr; end
      1: begin d_readM = 1'b1; d_address = addr; end
      2: begin d_writeM = 1'b1; d_address = addr; d_wdata = wd; end
      default: begin d_readM = 1'b1; d_writeM = 1'b1; d_address = addr; d_wdata = wd; end
    endcase
    @(negedge clk);
    check("busy_after_accept", {31'd0, busy}, 32'd1);
    if (scramble) begin
      i_address = WS'($urandom);
      d_address = WS'($urandom);
      d_wdata   = WS'($urandom);
    end
    wait_ack(kind != 0, cyc, ok);
    check("ack_latency", ok ? cyc : -1, LAT);
    case (kind)
      0: begin exp_i_data = model_mem[idx]; n_if++; end
      1: begin exp_d_rdata = model_mem[idx]; n_dr++; end
      default: begin model_mem[idx] = wd; n_dw++; end
    endcase
    check("i_data", {16'd0, i_data}, {16'd0, exp_i_data});
    check("d_rdata", {16'd0, d_rdata}, {16'd0, exp_d_rdata});
    check("other_ack_low", {31'd0, (kind == 0) ? d_ack : i_ack}, 32'd0);
    i_readM = 1'b0; d_readM = 1'b0; d_writeM = 1'b0;
    @(negedge clk);
    check("ack_one_cycle", {30'd0, i_ack, d_ack}, 32'd0);
    check("idle_after_ack", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc;
    bit ok;
    logic [WS-1:0] v;

    // Reset values
    #1 reset_n = 1'b0;
    #2;
    check("rst_i_ack", {31'd0, i_ack}, 32'd0);
    check("rst_d_ack", {31'd0, d_ack}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_i_data", {16'd0, i_data}, 32'd0);
    check("rst_d_rdata", {16'd0, d_rdata}, 32'd0);
`ifdef MEM_RESPONDER_STATS_EN
    check("rst_stats", {stat_ifetch, stat_dread | stat_dwrite}, 32'd0);
`endif
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Preload array and model identically
    for (int i = 0; i < 256; i++) begin
      v = WS'($urandom);
      model_mem[i] = v;
      dut.mem[i] = v;
    end
    model_mem[8'h10] = 16'h1234; dut.mem[8'h10] = 16'h1234;
    model_mem[8'h30] = 16'h1111; dut.mem[8'h30] = 16'h1111;

    // Basic fetch, then write / read-back
    do_txn(0, 16'h0010, 16'h0000, 1'b0);
    do_txn(2, 16'h0020, 16'hBEEF, 1'b0);
    do_txn(1, 16'h0020, 16'h0000, 1'b0);
    check("readback_beef", {16'd0, d_rdata}, 32'h0000BEEF);

    // Contention: data wins, fetch follows LAT+2 edges after the data ack
    i_readM = 1'b1; i_address = 16'h0001;
    d_readM = 1'b1; d_address = 16'h0002;
    wait_ack(1'b1, cyc, ok);
    check("cont_d_latency", ok ? cyc : -1, LAT + 1);
    check("cont_i_ack_low", {31'd0, i_ack}, 32'd0);
    exp_d_rdata = model_mem[8'h02]; n_dr++;
    check("cont_d_rdata", {16'd0, d_rdata}, {16'd0, exp_d_rdata});
    d_readM = 1'b0;
    wait_ack(1'b0, cyc, ok);
    check("cont_i_gap", ok ? cyc : -1, LAT + 2);
    check("cont_d_ack_low", {31'd0, d_ack}, 32'd0);
    exp_i_data = model_mem[8'h01]; n_if++;
    check("cont_i_data", {16'd0, i_data}, {16'd0, exp_i_data});
    i_readM = 1'b0;
    @(negedge clk);
    check("cont_idle", {29'd0, busy, i_ack, d_ack}, 32'd0);

    // Wrap and read+write conflict
    do_txn(2, 16'h0105, 16'h00AA, 1'b0);
    do_txn(1, 16'h0005, 16'h0000, 1'b0);
    check("wrap_readback", {16'd0, d_rdata}, 32'h000000AA);
    do_txn(3, 16'h0042, 16'hC0DE, 1'b0);
    do_txn(1, 16'h0042, 16'h0000, 1'b0);
    check("rw_conflict_write", {16'd0, d_rdata}, 32'h0000C0DE);

    // Reset abort during BUSY
    d_writeM = 1'b1; d_address = 16'h0030; d_wdata = 16'h5A5A;
    @(negedge clk);
    check("abort_busy", {31'd0, busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("abort_outputs", {29'd0, busy, i_ack, d_ack}, 32'd0);
    check("abort_data", {i_data, d_rdata}, 32'd0);
    d_writeM = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_no_ack", {30'd0, i_ack, d_ack}, 32'd0);
    reset_n = 1'b1;
    exp_i_data = '0; exp_d_rdata = '0;
    n_if = 0; n_dr = 0; n_dw = 0;
`ifdef MEM_RESPONDER_STATS_EN
    check("abort_stats", {stat_ifetch, stat_dread | stat_dwrite}, 32'd0);
`endif
    do_txn(1, 16'h0030, 16'h0000, 1'b0);
    check("abort_mem_kept", {16'd0, d_rdata}, 32'h00001111);

    // 3 fetches, 2 reads, 1 write since reset
    do_txn(0, 16'h0010, 16'h0000, 1'b0);
    do_txn(0, 16'h0011, 16'h0000, 1'b1);
    do_txn(0, 16'h0012, 16'h0000, 1'b0);
    do_txn(1, 16'h0013, 16'h0000, 1'b1);
    do_txn(2, 16'h0014, 16'h7777, 1'b1);
`ifdef MEM_RESPONDER_STATS_EN
    check("stat_ifetch", {16'd0, stat_ifetch}, 32'd3);
    check("stat_dread", {16'd0, stat_dread}, 32'd2);
    check("stat_dwrite", {16'd0, stat_dwrite}, 32'd1);
`endif

    // Random transactions, with inputs scrambled mid-flight
    for (int t = 0; t < 60; t++) begin
      do_txn(int'($urandom_range(0, 3)), WS'($urandom), WS'($urandom),
             1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
`ifdef MEM_RESPONDER_STATS_EN
    check("stat_ifetch_final", {16'd0, stat_ifetch}, n_if);
    check("stat_dread_final", {16'd0, stat_dread}, n_dr);
    check("stat_dwrite_final", {16'd0, stat_dwrite}, n_dw);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the 16-bit pipelined CPU. It answers IF-stage instruction fetches and MEM-stage data reads/writes, which are the requests issued by the pipeline registers.
- A single-ported internal word array is shared by both request channels. It has fixed, parameterised access latency and uses a request/ack handshake.
- Data-channel requests take priority over instruction fetches, since the MEM-stage instruction is older.
- CPU-side stall logic waits on the ack signals.

Parameters:
- WORD_SIZE, 16, data and address width in bits.
- ADDR_BITS, 8, index bits into the array. Depth = 2**ADDR_BITS words.
- LATENCY, 2, cycles from the accepting edge to the edge that raises ack. Legal range 1..15.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- i_readM  in  1  instruction fetch request; held high until i_ack
- i_address  in  WORD_SIZE  fetch address
- i_data  out  WORD_SIZE  fetched word; registered, holds its value until the next i_ack
- i_ack  out  1  one-cycle pulse; i_data is valid in the same cycle
- d_readM  in  1  data read request; held until d_ack
- d_writeM  in  1  data write request; held until d_ack
- d_address  in  WORD_SIZE  data address
- d_wdata  in  WORD_SIZE  write data
- d_rdata  out  WORD_SIZE  read data; registered, holds its value until the next read ack
- d_ack  out  1  one-cycle pulse; completes a read or write
- busy  out  1  high whenever state != IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on reset_n.
- Reset values:
  - state = IDLE.
  - i_ack = d_ack = 0, busy = 0, counter = 0.
  - i_data = d_rdata = 0.
  - Array contents are not reset. The bench preloads them through the hierarchical array mem.
- States: IDLE, BUSY, ACK.
- IDLE: requests are sampled only at edges in this state.
  - If d_readM or d_writeM is high: accept the data channel.
  - Else if i_readM is high: accept the instruction channel.
  - Accepting latches channel, op, index = address[ADDR_BITS-1:0], and wdata.
  - Accepting loads counter = LATENCY-1 and moves to BUSY.
  - With no request, stay in IDLE.
- BUSY:
  - While counter != 0, the counter decrements.
  - At the edge where counter == 0:
    - perform the access: read into i_data/d_rdata, or write mem[index];
    - raise the selected channel's ack;
    - move to ACK.
- ACK:
  - The ack is high for exactly this one cycle.
  - At the next edge: ack = 0, return to IDLE.
  - No request is sampled in ACK. This guarantees a held request is not re-accepted.
- Latency: ack rises on the LATENCY-th rising edge after the accepting edge. Accept-to-next-accept = LATENCY+2 edges.
- Latching: input changes during BUSY/ACK are ignored, because the latched copies are used.
- Address width: addresses wrap modulo the depth; upper bits are ignored.
- Simultaneous d_readM and d_writeM: treated as a write. d_rdata is unchanged.
- Simultaneous i_readM and d request in IDLE: the data channel is served. The instruction request stays pending and is accepted at the first IDLE edge after the data ack.
- Write completion: a write commits only at the ack edge. d_rdata does not change on writes.
- Reset mid-operation: the transaction is aborted, no write is performed, and all outputs take their reset values immediately.

Optional Feature:
- Macro: MEM_RESPONDER_STATS_EN.
- Defined: adds three output ports, each WORD_SIZE wide:
  - stat_ifetch: count of completed fetch acks;
  - stat_dread: count of completed data-read acks;
  - stat_dwrite: count of completed data-write acks.
  - Each counter increments at its ack edge, saturates at 16'hFFFF, and resets to 0.
- Undefined: the ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Reset, then preload mem[8'h10] = 16'h1234 and hold i_readM = 1 with i_address = 16'h0010 → i_ack rises exactly 2 edges after acceptance. i_data = 16'h1234 during the pulse. i_ack is one cycle wide and busy is low afterwards.
- Write then read, LATENCY = 2:
  - d_writeM with d_address = 16'h0020 and d_wdata = 16'hBEEF → d_ack pulse; d_rdata stays 0.
  - Then d_readM to 16'h0020 → d_rdata = 16'hBEEF.
- Contention: i_readM (addr 16'h0001) and d_readM (addr 16'h0002) are raised in the same cycle → d_ack comes first. i_ack follows LATENCY+2 edges later. Neither ack overlaps the other.
- Wrap and conflict:
  - d_writeM with d_address = 16'h0105 and d_wdata = 16'h00AA → mem[8'h05] = 16'h00AA.
  - d_readM and d_writeM both high → treated as a write; d_rdata is unchanged.
- Reset abort: d_writeM to 16'h0030 (prior content 16'h1111), with reset_n pulsed low during BUSY → no ack, outputs are 0, and mem[8'h30] is still 16'h1111.
- With MEM_RESPONDER_STATS_EN: 3 fetches, 2 reads and 1 write → stat_ifetch = 3, stat_dread = 2, stat_dwrite = 1. After reset all three are 0.
